// File: rtl/nios2_debug_cmd_queue_if.sv
// nios2_debug_cmd_queue_if: command-output handshake between the queue (master) and its consumer (slave).
interface nios2_debug_cmd_queue_if #(
  parameter int JDO_W = 38,
  parameter int IR_W  = 2
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [IR_W-1:0]      cmd_ir;
  logic [JDO_W-1:0]     jdo;
  logic [2**IR_W-1:0]   take_action;
  modport master (output cmd_valid, cmd_ir, jdo, take_action, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ir, jdo, take_action, output cmd_ready);
endinterface

// File: rtl/nios2_debug_cmd_queue.sv
// nios2_debug_cmd_queue: JTAG update-DR toggle synchroniser feeding a command FIFO with one-hot action pulses.
// Optional even-parity check on each command is enabled by defining NIOS2_DBG_CMD_PARITY_EN.
module nios2_debug_cmd_queue #(
  parameter int JDO_W       = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   upd_toggle,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [JDO_W-1:0]       sr,
  nios2_debug_cmd_queue_if.master cmd,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [7:0]             parity_err_cnt
);
  localparam int NA = 2**IR_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = IR_W + JDO_W;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   tog_dly_q;
  logic [EW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   valid_q, valid_d, ovf_q, ovf_d;
  logic [IR_W-1:0]        ir_q, ir_d;
  logic [JDO_W-1:0]       jdo_q, jdo_d;
  logic [NA-1:0]          act_q, act_d;
  logic                   push, par_ok, pop, full, wr;
  logic [EW-1:0]          head;
`ifdef NIOS2_DBG_CMD_PARITY_EN
  logic [7:0] perr_q, perr_d;
  // sr MSB carries even parity over the whole command, so a good word XORs to 0
  assign par_ok = ~^{ir_in, sr};
  assign perr_d = (push & ~par_ok & ~&perr_q) ? perr_q + 8'd1 : perr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) perr_q <= '0;
    else perr_q <= perr_d;
  assign parity_err_cnt = perr_q;
`else
  assign par_ok = 1'b1;
  assign parity_err_cnt = '0;
`endif
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], upd_toggle};
    push    = sync_q[SYNC_STAGES-1] ^ tog_dly_q;
    pop     = valid_q & cmd.cmd_ready;
    full    = level_q == LW'(DEPTH);
    wr      = push & par_ok & (~full | pop);
    head    = mem_q[rp_q];
    wp_d    = wp_q + AW'(wr);
    rp_d    = rp_q + AW'(pop);
    level_d = level_q + LW'(wr) - LW'(pop);
    valid_d = level_d != '0;
    ir_d    = pop ? head[JDO_W+:IR_W] : ir_q;
    jdo_d   = pop ? head[JDO_W-1:0] : jdo_q;
    act_d   = NA'(pop) << head[JDO_W+:IR_W];
    ovf_d   = (push & par_ok & full & ~pop) | (ovf_q & ~clr_overflow);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q    <= '0;
      tog_dly_q <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ir_q      <= '0;
      jdo_q     <= '0;
      act_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      tog_dly_q <= sync_q[SYNC_STAGES-1];
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      ir_q      <= ir_d;
      jdo_q     <= jdo_d;
      act_q     <= act_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= {ir_in, sr};
  assign cmd.cmd_valid   = valid_q;
  assign cmd.cmd_ir      = ir_q;
  assign cmd.jdo         = jdo_q;
  assign cmd.take_action = act_q;
  assign level           = level_q;
  assign overflow        = ovf_q;
endmodule

// File: tb/tb_nios2_debug_cmd_queue.sv
// tb_nios2_debug_cmd_queue: directed + randomized bench with a queue-level reference model.
module tb_nios2_debug_cmd_queue;
  localparam int JDO_W = 38, IR_W = 2, DEPTH = 4, SYNC_STAGES = 2, NA = 4, LW = 3;
  localparam logic [JDO_W-1:0] PBIT = {1'b1, {(JDO_W-1){1'b0}}};
  logic clk = 0, reset = 1, upd_toggle = 0, clr_overflow = 0;
  logic [IR_W-1:0] ir_in = '0;
  logic [JDO_W-1:0] sr = '0;
  logic [LW-1:0] level;
  logic overflow;
  logic [7:0] parity_err_cnt;
  int n_chk = 0, n_fail = 0, since = 0;
  bit chk_en = 0;
  nios2_debug_cmd_queue_if #(.JDO_W(JDO_W), .IR_W(IR_W)) cif();
  nios2_debug_cmd_queue #(.JDO_W(JDO_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .upd_toggle(upd_toggle), .ir_in(ir_in), .sr(sr), .cmd(cif),
    .level(level), .overflow(overflow), .clr_overflow(clr_overflow), .parity_err_cnt(parity_err_cnt)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [JDO_W-1:0] mk_sr(input logic [IR_W-1:0] i, input logic [JDO_W-1:0] p);
`ifdef NIOS2_DBG_CMD_PARITY_EN
    return {^{i, p[JDO_W-2:0]}, p[JDO_W-2:0]};
`else
    return p;
`endif
  endfunction

  function automatic logic par_ok(input logic [IR_W-1:0] i, input logic [JDO_W-1:0] s);
`ifdef NIOS2_DBG_CMD_PARITY_EN
    return (^{i, s}) == 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: a plain queue of commands; a toggle seen on edge n is acted on at edge n+SYNC_STAGES
  logic [IR_W+JDO_W-1:0] q[$];
  int due[$];
  int edge_n = 0;
  logic last_tog = 0, m_ovf = 0, m_pop, m_full, m_set;
  logic [7:0] m_perr = 0;
  logic [IR_W-1:0] m_ir = 0;
  logic [JDO_W-1:0] m_jdo = 0;
  logic [NA-1:0] m_act = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); due.delete();
      last_tog = 0; m_ovf = 0; m_perr = 0; m_ir = 0; m_jdo = 0; m_act = 0;
    end else begin
      edge_n++;
      m_pop = q.size() != 0 && cif.cmd_ready;
      m_full = q.size() == DEPTH;
      m_set = 0;
      m_act = 0;
      if (m_pop) begin
        m_ir = q[0][JDO_W+:IR_W];
        m_jdo = q[0][JDO_W-1:0];
        m_act = NA'(1) << m_ir;
        void'(q.pop_front());
      end
      if (due.size() != 0 && due[0] == edge_n) begin
        void'(due.pop_front());
        if (!par_ok(ir_in, sr)) m_perr = (m_perr == 8'hff) ? 8'hff : m_perr + 8'd1;
        else if (m_full && !m_pop) m_set = 1;
        else q.push_back({ir_in, sr});
      end
      m_ovf = m_set ? 1'b1 : clr_overflow ? 1'b0 : m_ovf;
      if (upd_toggle != last_tog) begin
        due.push_back(edge_n + SYNC_STAGES);
        last_tog = upd_toggle;
      end
    end
  end

  always @(posedge clk) if (chk_en) begin
    #2;
    chk("valid", 64'(cif.cmd_valid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("jdo", 64'(cif.jdo), 64'(m_jdo));
    chk("cmd_ir", 64'(cif.cmd_ir), 64'(m_ir));
    chk("take_action", 64'(cif.take_action), 64'(m_act));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("parity_err_cnt", 64'(parity_err_cnt), 64'(m_perr));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [IR_W-1:0] i, input logic [JDO_W-1:0] s);
    ir_in = i;
    sr = s;
    upd_toggle = ~upd_toggle;
    repeat (3) cyc();
  endtask

  initial begin
    cif.cmd_ready = 0;
    repeat (2) cyc();
    chk_en = 1;
    cyc();
    reset = 0;
    chk("rst_level", 64'(level), 0);
    chk("rst_valid", 64'(cif.cmd_valid), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_act", 64'(cif.take_action), 0);
    chk("rst_jdo", 64'(cif.jdo), 0);
    chk("rst_perr", 64'(parity_err_cnt), 0);
    // single command: valid on the third edge counting the sampling edge, pop on the next
    ir_in = 2'b10; sr = 38'h0_1234_5678; cif.cmd_ready = 1; upd_toggle = 1;
    cyc(); chk("t1_wait0", 64'(cif.cmd_valid), 0);
    cyc(); chk("t1_wait1", 64'(cif.cmd_valid), 0);
    cyc(); chk("t1_valid", 64'(cif.cmd_valid), 1); chk("t1_level", 64'(level), 1);
    cyc();
    chk("t1_jdo", 64'(cif.jdo), 64'h0_1234_5678);
    chk("t1_ir", 64'(cif.cmd_ir), 2);
    chk("t1_act", 64'(cif.take_action), 4'b0100);
    cyc(); chk("t1_act_end", 64'(cif.take_action), 0);
    cif.cmd_ready = 0;
    // fill and overflow; clear collides with the dropping push, set wins
    for (int n = 1; n <= 4; n++) push(IR_W'(n), mk_sr(IR_W'(n), JDO_W'(n)));
    chk("t2_full", 64'(level), 4);
    chk("t2_noovf", 64'(overflow), 0);
    ir_in = 2'd1; sr = mk_sr(2'd1, 38'd5); upd_toggle = ~upd_toggle;
    cyc(); cyc(); clr_overflow = 1; cyc(); clr_overflow = 0;
    chk("t2_ovf", 64'(overflow), 1);
    chk("t2_level", 64'(level), 4);
    cif.cmd_ready = 1;
    for (int n = 1; n <= 4; n++) begin
      cyc(); chk("t2_drain", 64'(cif.jdo), 64'(mk_sr(IR_W'(n), JDO_W'(n))));
    end
    cif.cmd_ready = 0;
    chk("t2_empty", 64'(level), 0);
    chk("t2_sticky", 64'(overflow), 1);
    clr_overflow = 1; cyc(); clr_overflow = 0;
    chk("t2_clr", 64'(overflow), 0);
    // full with simultaneous push and pop
    for (int n = 11; n <= 14; n++) push(IR_W'(n), mk_sr(IR_W'(n), JDO_W'(n)));
    ir_in = 2'd3; sr = mk_sr(2'd3, 38'd15); upd_toggle = ~upd_toggle;
    cyc(); cyc(); cif.cmd_ready = 1; cyc();
    chk("t3_level", 64'(level), 4);
    chk("t3_ovf", 64'(overflow), 0);
    chk("t3_head", 64'(cif.jdo), 64'(mk_sr(2'd3, 38'd11)));
    for (int n = 12; n <= 15; n++) begin
      cyc(); chk("t3_order", 64'(cif.jdo), 64'(mk_sr(IR_W'(n), JDO_W'(n))));
    end
    cif.cmd_ready = 0;
    // reset mid-queue, during a take_action pulse
    for (int n = 21; n <= 23; n++) push(IR_W'(n), mk_sr(IR_W'(n), JDO_W'(n)));
    cif.cmd_ready = 1; cyc();
    chk("t4_act", 64'(cif.take_action), 4'b0010);
    chk("t4_level", 64'(level), 2);
    cif.cmd_ready = 0; reset = 1; #1;
    chk("t4_act_rst", 64'(cif.take_action), 0);
    chk("t4_valid_rst", 64'(cif.cmd_valid), 0);
    chk("t4_level_rst", 64'(level), 0);
    cyc(); reset = 0;
    push(2'd0, mk_sr(2'd0, 38'd24));
    chk("t4_push", 64'(level), 1);
    cif.cmd_ready = 1; cyc(); cif.cmd_ready = 0;
    chk("t4_jdo", 64'(cif.jdo), 64'(mk_sr(2'd0, 38'd24)));
    // toggle held at 1 through reset yields exactly one push
    reset = 1; cyc(); reset = 0;
    repeat (6) cyc();
    chk("t5_one_push", 64'(level), 1);
    cif.cmd_ready = 1; cyc(); cif.cmd_ready = 0; cyc();
    chk("t5_drained", 64'(level), 0);
    // bad parity then good parity
    push(2'd1, mk_sr(2'd1, 38'd30) ^ PBIT);
    push(2'd1, mk_sr(2'd1, 38'd31));
`ifdef NIOS2_DBG_CMD_PARITY_EN
    chk("t6_level", 64'(level), 1);
    chk("t6_perr", 64'(parity_err_cnt), 1);
`else
    chk("t6_level", 64'(level), 2);
    chk("t6_perr", 64'(parity_err_cnt), 0);
`endif
    cif.cmd_ready = 1; repeat (2) cyc(); cif.cmd_ready = 0;
    chk("t6_drained", 64'(level), 0);
`ifdef NIOS2_DBG_CMD_PARITY_EN
    for (int n = 0; n < 260; n++) push(2'd0, mk_sr(2'd0, JDO_W'(n)) ^ PBIT);
    chk("t6_sat", 64'(parity_err_cnt), 255);
    chk("t6_sat_level", 64'(level), 0);
`endif
    // randomized traffic; toggles spaced so sr/ir stay stable until sampled
    since = 0;
    for (int i = 0; i < 2000; i++) begin
      if (since >= 3 && $urandom_range(0, 2) == 0) begin
        ir_in = IR_W'($urandom);
        sr = mk_sr(ir_in, JDO_W'({$urandom, $urandom}));
        if ($urandom_range(0, 7) == 0) sr ^= PBIT;
        upd_toggle = ~upd_toggle;
        since = 0;
      end else since++;
      cif.cmd_ready = ($urandom_range(0, 99) < (((i / 250) % 2) != 0 ? 75 : 15));
      clr_overflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1; cyc(); reset = 0; since = 0;
      end
      cyc();
    end
    cif.cmd_ready = 0; clr_overflow = 0;
    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
